// File: rtl/fifo_row_bank.sv
// Bank of independent, non-wrapping row FIFOs with pointer rewind for row replay.
// Shared write data, per-row strobes, 1-cycle read latency, sticky protocol error flags.
module fifo_row_bank #(
  parameter int unsigned NUM_FIFOS  = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 2048
) (
  input  logic                            FRB_Clk,
  input  logic                            FRB_Reset,
  input  logic [DATA_WIDTH-1:0]           FRB_Data_In,
  input  logic [NUM_FIFOS-1:0]            FRB_SetEn,
  input  logic [NUM_FIFOS-1:0]            FRB_OEn,
  input  logic [NUM_FIFOS-1:0]            FRB_Wptclr,
  input  logic [NUM_FIFOS-1:0]            FRB_Rptclr,
  input  logic                            FRB_Err_Clr,
  output logic [NUM_FIFOS*DATA_WIDTH-1:0] FRB_Data_Out,
  output logic [NUM_FIFOS-1:0]            FRB_Valid,
  output logic [NUM_FIFOS-1:0]            FRB_Empty,
  output logic [NUM_FIFOS-1:0]            FRB_Full,
  output logic [NUM_FIFOS-1:0]            FRB_Overflow,
  output logic [NUM_FIFOS-1:0]            FRB_Underflow
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  empty_c;
    logic                  full_c;
    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic                  ovf_evt_c;
    logic                  udf_evt_c;

    // Pointer clears take priority over the matching access strobe.
    assign empty_c   = (rptr >= wptr);
    assign full_c    = (wptr == PTR_W'(DEPTH));
    assign wr_ok_c   = FRB_SetEn[k] & ~FRB_Wptclr[k] & ~full_c;
    assign ovf_evt_c = FRB_SetEn[k] & ~FRB_Wptclr[k] &  full_c;
    assign rd_ok_c   = FRB_OEn[k]   & ~FRB_Rptclr[k] & ~empty_c;
    assign udf_evt_c = FRB_OEn[k]   & ~FRB_Rptclr[k] &  empty_c;

    // Storage is never reset or cleared; only the pointers rewind.
    always_ff @(posedge FRB_Clk) begin
      if (!FRB_Reset && wr_ok_c) begin
        mem[wptr[IDX_W-1:0]] <= FRB_Data_In;
      end
    end

    always_ff @(posedge FRB_Clk) begin
      if (FRB_Reset) begin
        wptr    <= '0;
        rptr    <= '0;
        dout_q  <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        if (FRB_Wptclr[k]) begin
          wptr <= '0;
        end else if (wr_ok_c) begin
          wptr <= wptr + PTR_W'(1);
        end

        if (FRB_Rptclr[k]) begin
          rptr <= '0;
        end else if (rd_ok_c) begin
          rptr <= rptr + PTR_W'(1);
        end

        valid_q <= rd_ok_c;
        if (rd_ok_c) begin
          dout_q <= mem[rptr[IDX_W-1:0]];
        end

        // A new error in the clearing cycle keeps the flag set.
        ovf_q <= (ovf_q & ~FRB_Err_Clr) | ovf_evt_c;
        udf_q <= (udf_q & ~FRB_Err_Clr) | udf_evt_c;
      end
    end

    assign FRB_Data_Out[k*DATA_WIDTH +: DATA_WIDTH] = dout_q;
    assign FRB_Valid[k]     = valid_q;
    assign FRB_Empty[k]     = empty_c;
    assign FRB_Full[k]      = full_c;
    assign FRB_Overflow[k]  = ovf_q;
    assign FRB_Underflow[k] = udf_q;
  end

endmodule

// File: tb/tb_fifo_row_bank.sv
// Scoreboard bench for fifo_row_bank (DEPTH=16 build): directed test-plan sequences
// followed by randomized strobes, checked against a queue/array reference model.
module tb_fifo_row_bank;

  localparam int unsigned NF = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 16;

  logic              tb_clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     din;
  logic [NF-1:0]     set_en, oen, wclr, rclr;
  logic              err_clr;
  logic [NF*DW-1:0]  dout;
  logic [NF-1:0]     valid, empty, full, ovf, udf;

  fifo_row_bank #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .FRB_Clk(tb_clk), .FRB_Reset(rst), .FRB_Data_In(din),
    .FRB_SetEn(set_en), .FRB_OEn(oen), .FRB_Wptclr(wclr), .FRB_Rptclr(rclr),
    .FRB_Err_Clr(err_clr), .FRB_Data_Out(dout), .FRB_Valid(valid),
    .FRB_Empty(empty), .FRB_Full(full), .FRB_Overflow(ovf), .FRB_Underflow(udf)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } exp_t;

  // Reference model: plain arrays of words plus integer pointers.
  logic [DW-1:0] m_mem [NF][DP];
  int            m_wp [NF];
  int            m_rp [NF];
  logic [DW-1:0] m_last [NF];
  logic [NF-1:0] m_valid, m_ovf, m_udf;
  exp_t          sb_q [NF][$];

  int  edge_n = 0;
  bit  mon_en = 1'b0;
  int  n_checks = 0;
  int  n_err = 0;

  always @(posedge tb_clk) edge_n <= edge_n + 1;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h expected %0h (edge %0d)", nm, idx, act, exp, edge_n);
    end
  endtask

  // One clock of stimulus; the model predicts the state seen after the next edge.
  task automatic step(input bit r, input logic [NF-1:0] s, input logic [NF-1:0] o,
                      input logic [NF-1:0] wc, input logic [NF-1:0] rc,
                      input bit ec, input logic [DW-1:0] d);
    @(negedge tb_clk);
    rst = r; set_en = s; oen = o; wclr = wc; rclr = rc; err_clr = ec; din = d;
    m_valid = '0;
    for (int k = 0; k < NF; k++) begin
      if (r) begin
        m_wp[k] = 0; m_rp[k] = 0; m_last[k] = '0;
        m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
      end else begin
        bit oe = 1'b0, ue = 1'b0;
        if (rc[k]) m_rp[k] = 0;
        else if (o[k]) begin
          if (m_rp[k] < m_wp[k]) begin
            exp_t e;
            e.d = m_mem[k][m_rp[k]];
            e.e = edge_n + 1;
            sb_q[k].push_back(e);
            m_last[k] = e.d;
            m_valid[k] = 1'b1;
            m_rp[k]++;
          end else ue = 1'b1;
        end
        if (wc[k]) m_wp[k] = 0;
        else if (s[k]) begin
          if (m_wp[k] < DP) begin
            m_mem[k][m_wp[k]] = d;
            m_wp[k]++;
          end else oe = 1'b1;
        end
        m_ovf[k] = (m_ovf[k] && !ec) || oe;
        m_udf[k] = (m_udf[k] && !ec) || ue;
      end
    end
    mon_en = 1'b1;
  endtask

  // Monitor: compare every output one tick after each active edge.
  always @(posedge tb_clk) begin
    #1;
    if (mon_en) begin
      check("valid_vec", 0, 32'(valid), 32'(m_valid));
      for (int k = 0; k < NF; k++) begin
        if (valid[k]) begin
          if (sb_q[k].size() == 0) begin
            check("spurious_valid", k, 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb_q[k].pop_front();
            check("read_data", k, 32'(dout[k*DW +: DW]), 32'(e.d));
            check("read_latency_edge", k, 32'(edge_n), 32'(e.e));
          end
        end
        check("data_out", k, 32'(dout[k*DW +: DW]), 32'(m_last[k]));
        check("empty", k, 32'(empty[k]), 32'(m_rp[k] >= m_wp[k]));
        check("full", k, 32'(full[k]), 32'(m_wp[k] == DP));
      end
      check("overflow_vec", 0, 32'(ovf), 32'(m_ovf));
      check("underflow_vec", 0, 32'(udf), 32'(m_udf));
    end
  end

  localparam logic [NF-1:0] Z = '0;
  localparam logic [NF-1:0] ALL = '1;

  initial begin
    rst = 1'b1; din = '0; set_en = '0; oen = '0; wclr = '0; rclr = '0; err_clr = 1'b0;

    // Reset, then fill FIFO 0 with 1..8 and read it back.
    step(1, Z, Z, Z, Z, 0, 0);
    step(1, Z, Z, Z, Z, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, NF'(1), Z, Z, Z, 0, DW'(i));
    for (int i = 0; i < 8; i++)  step(0, Z, NF'(1), Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 0, 0);

    // Rewind and replay FIFO 0.
    step(0, Z, Z, Z, NF'(1), 0, 0);
    for (int i = 0; i < 8; i++)  step(0, Z, NF'(1), Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 0, 0);

    // Overfill FIFO 3, then clear the sticky flag.
    for (int i = 0; i < 17; i++) step(0, NF'(1) << 3, Z, Z, Z, 0, DW'(8'h30 + i));
    step(0, Z, Z, Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 1, 0);
    step(0, Z, Z, Z, Z, 0, 0);

    // Underflow on empty FIFO 5.
    step(0, Z, NF'(1) << 5, Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 0, 0);

    // Clear-vs-access priority on FIFO 2.
    step(0, NF'(1) << 2, Z, Z, Z, 0, 8'hA5);
    step(0, NF'(1) << 2, Z, NF'(1) << 2, Z, 0, 8'h5A);
    step(0, Z, NF'(1) << 2, Z, NF'(1) << 2, 0, 0);
    step(0, Z, Z, Z, Z, 1, 0);

    // Clean slate, then distinct data into all FIFOs and a parallel read.
    step(1, Z, Z, Z, Z, 0, 0);
    for (int k = 0; k < NF; k++) step(0, NF'(1) << k, Z, Z, Z, 0, DW'(8'h10 + k));
    step(0, Z, ALL, Z, Z, 0, 0);
    step(0, Z, Z, Z, ALL, 0, 0);
    step(1, Z, ALL, Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [NF-1:0] s, o, wc, rc;
      s  = NF'($urandom) & NF'($urandom);
      o  = NF'($urandom);
      wc = ($urandom_range(0, 19) == 0) ? NF'($urandom) : Z;
      rc = ($urandom_range(0, 9) == 0) ? NF'($urandom) : Z;
      step(($urandom_range(0, 299) == 0), s, o, wc, rc, ($urandom_range(0, 24) == 0), DW'($urandom));
    end

    step(0, Z, Z, Z, Z, 0, 0);
    step(0, Z, Z, Z, Z, 0, 0);
    @(posedge tb_clk);
    #2;
    for (int k = 0; k < NF; k++) check("pending_reads", k, 32'(sb_q[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_row_bank.md
# fifo_row_bank

Bank of independent row FIFOs on the receiving end of the on-chip FIFO memory dataflow controller. Each FIFO acts on that controller's per-row SetEn, OEn, Wptclr and Rptclr strobes: it writes the shared input pixel stream, reads with one-cycle latency, and rewinds its pointers on command so a buffered image row can be replayed for vertically overlapping convolution windows. It sits between the input-feature-map stream and the convolution window/PE array, and reports per-row occupancy and sticky protocol errors.

## Interface
- NUM_FIFOS, 9: number of row FIFOs, one per controller channel 0..8.
- DATA_WIDTH, 8: pixel width.
- ADDR_WIDTH, 11: pointer address width; matches the controller's 11-bit column count.
- DEPTH, 2048: words per FIFO; must satisfy DEPTH <= 2^ADDR_WIDTH.
- FRB_Clk  in  1  single clock; all logic on rising edge.
- FRB_Reset  in  1  synchronous, active-high reset.
- FRB_Data_In  in  DATA_WIDTH  shared write data; all FIFOs see the same word.
- FRB_SetEn  in  NUM_FIFOS  bit k: write FRB_Data_In into FIFO k.
- FRB_OEn  in  NUM_FIFOS  bit k: read one word from FIFO k.
- FRB_Wptclr  in  NUM_FIFOS  bit k: clear FIFO k's write pointer.
- FRB_Rptclr  in  NUM_FIFOS  bit k: clear FIFO k's read pointer.
- FRB_Err_Clr  in  1  clears the sticky error flags.
- FRB_Data_Out  out  NUM_FIFOS*DATA_WIDTH  FIFO k output is bits [k*DATA_WIDTH +: DATA_WIDTH]; registered.
- FRB_Valid  out  NUM_FIFOS  bit k high for one cycle when FIFO k's output is new read data.
- FRB_Empty  out  NUM_FIFOS  bit k high when rptr_k >= wptr_k.
- FRB_Full  out  NUM_FIFOS  bit k high when wptr_k == DEPTH.
- FRB_Overflow  out  NUM_FIFOS  sticky; write attempted while full.
- FRB_Underflow  out  NUM_FIFOS  sticky; read attempted while empty.

## Operation
- Each FIFO k holds a memory of DEPTH x DATA_WIDTH, plus wptr_k and rptr_k, both ADDR_WIDTH+1 bits wide so they can hold the value DEPTH.
- There is no wrap-around. Pointers only count up, and return to 0 only through Wptclr, Rptclr or reset. This is a row buffer, not a ring.
- Write priority, per FIFO per cycle:
  - Wptclr: wptr_k <= 0 and no write; SetEn that cycle is ignored.
  - else SetEn and not Full: mem[wptr_k] <= FRB_Data_In, wptr_k += 1.
  - else SetEn and Full: no write, Overflow_k <= 1.
- Read priority, per FIFO per cycle:
  - Rptclr: rptr_k <= 0 and no read; OEn is ignored and Valid_k = 0 next cycle.
  - else OEn and not Empty: Data_Out_k <= mem[rptr_k], rptr_k += 1, Valid_k = 1 next cycle.
  - else OEn and Empty: Data_Out_k holds, rptr unchanged, Underflow_k <= 1, Valid_k = 0.
- The write side and the read side of one FIFO are independent. Wptclr together with OEn is legal. Rptclr together with SetEn is legal.
- A read in the same cycle as a write to the same FIFO uses the pre-write pointers. When rptr_k == wptr_k the read is an underflow; write-through data is not forwarded.
- Replay: after Rptclr_k, data already written can be read again; memory is never cleared by pointer clears.
- Empty and Full are combinational from the current pointers.
- Error flags are set per FIFO and remain set until FRB_Err_Clr or reset. If FRB_Err_Clr and a new error occur in the same cycle, the set wins.
- Simultaneous strobes on different FIFOs are fully independent.

## Timing
- Write: data is stored at the edge where SetEn is sampled. Empty can deassert from the next cycle.
- Read latency is 1 cycle. OEn sampled at edge N gives Data_Out and Valid at edge N+1. Valid is a single-cycle pulse per accepted read.
- Back-to-back OEn gives one word per cycle.
- Reset values:
  - all pointers 0
  - FRB_Data_Out = 0
  - FRB_Valid = 0
  - FRB_Empty = all ones
  - FRB_Full = 0
  - FRB_Overflow = 0, FRB_Underflow = 0
- Memory contents are not reset.
- Reset mid-operation: reset overrides every strobe in that cycle. A read accepted in the cycle before reset may still present its data, but reset forces Valid to 0.

## Test plan
- Reset, then SetEn[0] for 8 cycles with data 1..8, then OEn[0] for 8 cycles -> Data_Out_0 = 1..8, each one cycle after its OEn, with Valid[0] high for 8 consecutive cycles; Empty[0] = 1 afterwards.
- After the first test, pulse Rptclr[0], then OEn[0] x8 -> 1..8 replayed. Underflow[0] stays 0.
- DEPTH=16 build: 17 writes to FIFO 3 -> Full[3] = 1 after the 16th write; the 17th write leaves wptr unchanged and sets Overflow[3]. The flag holds until Err_Clr, then reads 0.
- OEn[5] on an empty FIFO -> Valid[5] = 0, Data_Out_5 unchanged, Underflow[5] = 1.
- Same cycle: Wptclr[2] + SetEn[2] -> no write, wptr_2 = 0. Then Rptclr[2] + OEn[2] -> Valid[2] = 0 next cycle.
- All 9 FIFOs written 0x10+k, then OEn all ones -> every slice k reads 0x10+k in the same cycle. Reset asserted during this read -> Valid = 0 and Data_Out = 0 the next cycle.
